// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encoding and
// the default NOP instruction.
package pipe_pkg;

  // Occupancy doubles as the state: number of valid entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with an increment enable; cleared only by reset.
module pipe_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer, flush and stall.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INS_W  = 32,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEFAULT)
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clkIn,
  input  logic              resetIn,
  input  logic              flushIn,
  input  logic              stallIn,
  input  logic              validIn,
  output logic              readyOut,
  input  logic [ADDR_W-1:0] AddrIn,
  input  logic [INS_W-1:0]  InsIn,
  output logic              validOut,
  input  logic              readyIn,
  output logic [ADDR_W-1:0] AddrOut,
  output logic [INS_W-1:0]  InsOut,
  output logic [1:0]        occupancyOut
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stallCntOut
  , output logic [CNT_W-1:0] flushCntOut
`endif
);

  occ_state_t        state, next_state;
  logic              ready_reg;
  logic [ADDR_W-1:0] main_addr, skid_addr;
  logic [INS_W-1:0]  main_ins, skid_ins;
  logic              take, give;
  logic              load_main, load_skid, skid_to_main;

  assign validOut     = (state != EMPTY);
  assign readyOut     = ready_reg;
  assign AddrOut      = main_addr;
  assign InsOut       = main_ins;
  assign occupancyOut = state;

  assign take = validIn & ready_reg;
  assign give = validOut & readyIn & ~stallIn;

  always_comb begin
    next_state   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (take) begin
          next_state = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (take && !give) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (take && give) begin
          load_main = 1'b1;
        end else if (give) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (give) begin
          next_state   = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
    // Flush overrides every other transition and drops the incoming entry.
    if (flushIn) begin
      next_state   = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // Ready is registered from the next state so it never depends on readyIn/stallIn/flushIn combinationally.
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state     <= EMPTY;
      ready_reg <= 1'b1;
    end else begin
      state     <= next_state;
      ready_reg <= (next_state != FULL);
    end
  end

  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      main_addr <= '0;
      main_ins  <= NOP_INS;
      skid_addr <= '0;
      skid_ins  <= NOP_INS;
    end else if (flushIn) begin
      main_addr <= '0;
      main_ins  <= NOP_INS;
    end else begin
      if (load_main) begin
        main_addr <= AddrIn;
        main_ins  <= InsIn;
      end else if (skid_to_main) begin
        main_addr <= skid_addr;
        main_ins  <= skid_ins;
      end
      if (load_skid) begin
        skid_addr <= AddrIn;
        skid_ins  <= InsIn;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clkIn),
    .rst   (resetIn),
    .inc   (validOut & stallIn),
    .count (stallCntOut)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clkIn),
    .rst   (resetIn),
    .inc   (flushIn),
    .count (flushCntOut)
  );
`endif

endmodule
